// File: rtl/vga_pixel_pkg.sv
// Shared definitions for the VGA pixel write controller: resolution defaults and
// the command record carried from the PIO capture stage to the frame-buffer writer.
package vga_pixel_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int PIX_DATA_W = 16;

    typedef struct packed {
        logic [15:0]           row;
        logic [15:0]           col;
        logic [PIX_DATA_W-1:0] data;
    } pix_cmd_t;

endpackage

// File: rtl/vga_pixel_cmd_fifo.sv
// Synchronous command FIFO for pixel writes; full is registered from the
// next-state count so it is glitch-free at the capture stage.
module vga_pixel_cmd_fifo
    import vga_pixel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  pix_cmd_t cmd_i,
    input  logic     pop_i,
    output pix_cmd_t cmd_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pix_cmd_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               full_q;
    logic               push_ok;
    logic               pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = full_q;
    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign cmd_o   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= cmd_i;
    end

endmodule

// File: rtl/vga_pixel_write_ctrl.sv
// Captures CPU pixel commands on a commit rising edge and turns each into one
// Avalon-MM frame-buffer write. Optional drop counter: VGA_PIXEL_DROP_CNT_EN.
module vga_pixel_write_ctrl
    import vga_pixel_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int DATA_W     = PIX_DATA_W,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       pixel_index_in_row,
    input  logic [15:0]       pixel_row,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic              commit,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic              mem_waitrequest,
    output logic              busy,
    output logic              fifo_full,
    output logic              drop_err
`ifdef VGA_PIXEL_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    logic              commit_d_q;
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              drop_err_q;
    logic              commit_edge;
    logic              in_range;
    logic              push;
    logic              drop;
    logic              pop;
    logic              fifo_empty;
    pix_cmd_t          cmd_in;
    pix_cmd_t          cmd_out;

    assign commit_edge = commit & ~commit_d_q;
    assign in_range    = (32'(pixel_index_in_row) < H_RES) && (32'(pixel_row) < V_RES);
    // Full is judged before any same-cycle pop, so a pop never rescues a command.
    assign push        = commit_edge & in_range & ~fifo_full;
    assign drop        = commit_edge & ~push;
    assign pop         = (state_q == ST_IDLE) & ~fifo_empty;

    assign cmd_in.row  = pixel_row;
    assign cmd_in.col  = pixel_index_in_row;
    assign cmd_in.data = PIX_DATA_W'(pixel_data);

    vga_pixel_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .cmd_i   (cmd_in),
        .pop_i   (pop),
        .cmd_o   (cmd_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    addr_d  = ADDR_W'(cmd_out.row) * ADDR_W'(H_RES) + ADDR_W'(cmd_out.col);
                    data_d  = DATA_W'(cmd_out.data);
                    state_d = ST_WRITE;
                end
            end
            default: begin
                if (!mem_waitrequest) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_d_q <= 1'b0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            drop_err_q <= 1'b0;
        end else begin
            commit_d_q <= commit;
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            if (drop)           drop_err_q <= 1'b1;
            else if (clear_err) drop_err_q <= 1'b0;
        end
    end

`ifdef VGA_PIXEL_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end else if (clear_err) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign mem_write     = (state_q == ST_WRITE);
    assign mem_address   = addr_q;
    assign mem_writedata = data_q;
    assign busy          = ~fifo_empty | (state_q == ST_WRITE);
    assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_vga_pixel_write_ctrl.sv
// Scoreboard bench for vga_pixel_write_ctrl: directed scenarios plus randomized bursts.
module tb_vga_pixel_write_ctrl;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int DW = 16;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   pixel_index_in_row = '0;
    logic [15:0]   pixel_row = '0;
    logic [DW-1:0] pixel_data = '0;
    logic          commit = 1'b0;
    logic          clear_err = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_waitrequest = 1'b0;
    logic          busy;
    logic          fifo_full;
    logic          drop_err;
`ifdef VGA_PIXEL_DROP_CNT_EN
    logic [7:0]    drop_count;
`endif

    vga_pixel_write_ctrl dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .pixel_index_in_row (pixel_index_in_row),
        .pixel_row          (pixel_row),
        .pixel_data         (pixel_data),
        .commit             (commit),
        .clear_err          (clear_err),
        .mem_address        (mem_address),
        .mem_write          (mem_write),
        .mem_writedata      (mem_writedata),
        .mem_waitrequest    (mem_waitrequest),
        .busy               (busy),
        .fifo_full          (fifo_full),
        .drop_err           (drop_err)
`ifdef VGA_PIXEL_DROP_CNT_EN
        ,
        .drop_count         (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   n_writes = 0;
    int   wr_hi_cycles = 0;
    bit   rand_wait = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the bus shows a write, it must match the oldest expected command.
    always @(negedge clk) begin
        if (reset_n && mem_write) begin
            wr_hi_cycles++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         mem_address, mem_writedata);
            end else begin
                check("wr_addr", 32'(mem_address), exp_q[0].addr);
                check("wr_data", 32'(mem_writedata), exp_q[0].data);
                if (!mem_waitrequest) begin
                    void'(exp_q.pop_front());
                    n_writes++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_wait) mem_waitrequest = ($urandom_range(0, 2) == 0);
    endtask

    // Reference rule: a command is written iff in range and the queue had room.
    task automatic send(input int c, input int r, input int d, input bit model_full,
                        input int hi, input int lo, output bit dropped);
        exp_t e;
        pixel_index_in_row = 16'(c);
        pixel_row          = 16'(r);
        pixel_data         = DW'(d);
        commit             = 1'b1;
        dropped = !((c < H) && (r < V) && !model_full);
        if (!dropped) begin
            e.addr = (r * H + c) % (1 << AW);
            e.data = d % (1 << DW);
            exp_q.push_back(e);
        end
        repeat (hi) tick();
        commit = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        bit dr;
        bit exp_drop;
        int w0;
        int h0;
        int c, r, nb, sel;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_full", 32'(fifo_full), 0);
        check("rst_drop_err", 32'(drop_err), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_wdata", 32'(mem_writedata), 0);
        reset_n = 1'b1;
        tick();

        // 1: basic write and two-cycle latency
        exp_q.push_back('{addr: 1285, data: 32'hF800});
        pixel_index_in_row = 16'd5;
        pixel_row = 16'd2;
        pixel_data = 16'hF800;
        commit = 1'b1;
        @(negedge clk);
        check("t1_cycN", 32'(mem_write), 0);
        tick();
        commit = 1'b0;
        @(negedge clk);
        check("t1_cycN1", 32'(mem_write), 0);
        @(negedge clk);
        check("t1_cycN2", 32'(mem_write), 1);
        check("t1_addr", 32'(mem_address), 1285);
        check("t1_data", 32'(mem_writedata), 32'hF800);
        @(negedge clk);
        check("t1_cycN3", 32'(mem_write), 0);
        wait_idle("t1_idle");

        // 2: three stall cycles hold the write for four cycles
        mem_waitrequest = 1'b1;
        h0 = wr_hi_cycles;
        send(100, 7, 16'h1234, 1'b0, 1, 1, dr);
        repeat (3) tick();
        mem_waitrequest = 1'b0;
        wait_idle("t2_idle");
        check("t2_hi_cycles", 32'(wr_hi_cycles - h0), 4);

        // 3: one stalled write in flight, then five commits: four queue, fifth drops
        mem_waitrequest = 1'b1;
        w0 = n_writes;
        send(1, 1, 16'hA000, 1'b0, 1, 1, dr);
        for (int k = 0; k < 5; k++) begin
            send(10 + k, 20 + k, 16'h0100 + k, (k >= 4), 1, 1, dr);
            check("t3_model_drop", 32'(dr), 32'(k >= 4));
        end
        check("t3_fifo_full", 32'(fifo_full), 1);
        check("t3_drop_err", 32'(drop_err), 1);
        check("t3_busy", 32'(busy), 1);
        mem_waitrequest = 1'b0;
        wait_idle("t3_idle");
        check("t3_writes", 32'(n_writes - w0), 5);
        check("t3_full_after", 32'(fifo_full), 0);
        clear_pulse();
        check("t3_clear", 32'(drop_err), 0);

        // 4: column out of range, then clear, then set-over-clear priority
        w0 = n_writes;
        send(640, 0, 16'hFFFF, 1'b0, 1, 1, dr);
        check("t4_drop_err", 32'(drop_err), 1);
        check("t4_busy", 32'(busy), 0);
        repeat (4) tick();
        check("t4_no_write", 32'(n_writes - w0), 0);
        clear_pulse();
        check("t4_cleared", 32'(drop_err), 0);
        clear_err = 1'b1;
        send(100, 480, 16'h0001, 1'b0, 1, 0, dr);
        clear_err = 1'b0;
        tick();
        check("t4_set_wins", 32'(drop_err), 1);
        clear_pulse();
        check("t4_cleared2", 32'(drop_err), 0);

        // 5: commit held high gives exactly one write
        w0 = n_writes;
        send(639, 479, 16'h07E0, 1'b0, 10, 1, dr);
        wait_idle("t5_idle");
        check("t5_writes", 32'(n_writes - w0), 1);

        // Random bursts with random slave stalls
        rand_wait = 1'b1;
        for (int b = 0; b < 30; b++) begin
            clear_pulse();
            check("rnd_clear", 32'(drop_err), 0);
            nb = $urandom_range(1, 3);
            exp_drop = 1'b0;
            for (int k = 0; k < nb; k++) begin
                c = $urandom_range(0, 700);
                r = $urandom_range(0, 520);
                sel = $urandom_range(0, 7);
                if (sel == 0) c = 639;
                if (sel == 1) c = 640;
                if (sel == 2) r = 479;
                if (sel == 3) r = 480;
                send(c, r, $urandom_range(0, 65535), 1'b0,
                     $urandom_range(1, 3), $urandom_range(1, 2), dr);
                exp_drop |= dr;
            end
            wait_idle("rnd_idle");
            check("rnd_drop_err", 32'(drop_err), 32'(exp_drop));
        end
        rand_wait = 1'b0;
        mem_waitrequest = 1'b0;
        tick();

`ifdef VGA_PIXEL_DROP_CNT_EN
        clear_pulse();
        check("cnt_clear0", 32'(drop_count), 0);
        send(700, 0, 0, 1'b0, 1, 1, dr);
        check("cnt_one", 32'(drop_count), 1);
        for (int k = 1; k < 300; k++) send(700, 0, 0, 1'b0, 1, 1, dr);
        check("cnt_sat", 32'(drop_count), 255);
        clear_pulse();
        check("cnt_clear", 32'(drop_count), 0);
        clear_pulse();
`endif

        // 6: asynchronous reset during a stalled write
        mem_waitrequest = 1'b1;
        w0 = n_writes;
        send(3, 3, 16'h00AA, 1'b0, 1, 1, dr);
        send(4, 4, 16'h00BB, 1'b0, 1, 1, dr);
        send(5, 5, 16'h00CC, 1'b0, 1, 1, dr);
        check("t6_pre_write", 32'(mem_write), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_mem_write", 32'(mem_write), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_full", 32'(fifo_full), 0);
        exp_q.delete();
        tick();
        tick();
        mem_waitrequest = 1'b0;
        reset_n = 1'b1;
        repeat (6) tick();
        check("t6_busy_after", 32'(busy), 0);
        check("t6_no_retry", 32'(n_writes - w0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
